// File: rtl/uart_rx_oversample.sv
// UART receiver: 16x oversampled, 3-sample majority vote per bit, optional parity,
// 1 or 2 stop bits, valid/ready byte output with sticky error flags.
module uart_rx_oversample #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             uart_en,
    input  logic             rx_en,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             parity_enable,
    input  logic             parity,
    input  logic             stop_bit,
    input  logic             status_clr,
    input  logic             rx,
    output logic [7:0]       rx_data,
    output logic             rx_perr,
    output logic             rx_ferr,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             busy,
    output logic             parity_error,
    output logic             frame_error,
    output logic             overrun_error
);

    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam logic [SCNT_W-1:0] SC_S0   = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] SC_S1   = SCNT_W'(OVERSAMPLE / 2);
    localparam logic [SCNT_W-1:0] SC_MID  = SCNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SCNT_W-1:0] SC_LAST = SCNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_e;

    state_e             state_q, state_d;
    logic               rx_meta_q, rx_meta_d, rx_s_q, rx_s_d, rx_prev_q, rx_prev_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [SCNT_W-1:0]  scnt_q, scnt_d;
    logic [1:0]         samp_q, samp_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         data_q, data_d;
    logic               perr_q, perr_d, ferr_q, ferr_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d, rx_valid_q, rx_valid_d;
    logic               parity_error_q, parity_error_d, frame_error_q, frame_error_d;
    logic               overrun_error_q, overrun_error_d;

    logic enabled, tick, at_mid, at_last, bit_v, deliver;

    assign enabled = uart_en & rx_en;
    assign tick    = (state_q != S_IDLE) && (div_q == baud_div);
    assign at_mid  = tick && (scnt_q == SC_MID);
    assign at_last = tick && (scnt_q == SC_LAST);
    // Samples at counts 7 and 8 are held; the third is the live value at the count-9 tick.
    assign bit_v   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        rx_meta_d       = rx;
        rx_s_d          = rx_meta_q;
        rx_prev_d       = rx_s_q;
        state_d         = state_q;
        div_d           = div_q;
        scnt_d          = scnt_q;
        samp_d          = samp_q;
        bit_cnt_d       = bit_cnt_q;
        data_d          = data_q;
        perr_d          = perr_q;
        ferr_d          = ferr_q;
        rx_data_d       = rx_data_q;
        rx_perr_d       = rx_perr_q;
        rx_ferr_d       = rx_ferr_q;
        rx_valid_d      = rx_valid_q & ~rx_ready;
        parity_error_d  = parity_error_q & ~status_clr;
        frame_error_d   = frame_error_q & ~status_clr;
        overrun_error_d = overrun_error_q & ~status_clr;
        deliver         = 1'b0;

        if (state_q != S_IDLE) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                scnt_d = scnt_q + SCNT_W'(1);
                if (scnt_q == SC_S0) samp_d[0] = rx_s_q;
                if (scnt_q == SC_S1) samp_d[1] = rx_s_q;
            end
        end

        if (!enabled && state_q != S_IDLE) begin
            state_d = S_IDLE;
            div_d   = '0;
            scnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enabled && rx_prev_q && !rx_s_q) begin
                        state_d   = S_START;
                        div_d     = '0;
                        scnt_d    = '0;
                        bit_cnt_d = '0;
                        perr_d    = 1'b0;
                        ferr_d    = 1'b0;
                    end
                end
                S_START: begin
                    if (at_mid && bit_v) state_d = S_IDLE;
                    else if (at_last)    state_d = S_DATA;
                end
                S_DATA: begin
                    if (at_mid) data_d = {bit_v, data_q[7:1]};
                    if (at_last) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = parity_enable ? S_PARITY : S_STOP1;
                    end
                end
                S_PARITY: begin
                    if (at_mid)  perr_d  = ^data_q ^ bit_v ^ parity;
                    if (at_last) state_d = S_STOP1;
                end
                S_STOP1: begin
                    if (at_mid) begin
                        ferr_d = ferr_q | ~bit_v;
                        if (!stop_bit) begin
                            deliver = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (at_last) begin
                        state_d = S_STOP2;
                    end
                end
                S_STOP2: begin
                    if (at_mid) begin
                        ferr_d  = ferr_q | ~bit_v;
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Delivery lands mid stop bit; forcing rx_prev high lets a still-low line
        // (break) register as the next start edge.
        if (deliver) begin
            rx_prev_d = 1'b1;
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = data_q;
                rx_perr_d  = perr_q;
                rx_ferr_d  = ferr_d;
                rx_valid_d = 1'b1;
            end else begin
                overrun_error_d = 1'b1;
            end
            if (perr_q) parity_error_d = 1'b1;
            if (ferr_d) frame_error_d  = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            rx_meta_q       <= 1'b1;
            rx_s_q          <= 1'b1;
            rx_prev_q       <= 1'b1;
            div_q           <= '0;
            scnt_q          <= '0;
            samp_q          <= '0;
            bit_cnt_q       <= '0;
            data_q          <= '0;
            perr_q          <= 1'b0;
            ferr_q          <= 1'b0;
            rx_data_q       <= '0;
            rx_perr_q       <= 1'b0;
            rx_ferr_q       <= 1'b0;
            rx_valid_q      <= 1'b0;
            parity_error_q  <= 1'b0;
            frame_error_q   <= 1'b0;
            overrun_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rx_meta_q       <= rx_meta_d;
            rx_s_q          <= rx_s_d;
            rx_prev_q       <= rx_prev_d;
            div_q           <= div_d;
            scnt_q          <= scnt_d;
            samp_q          <= samp_d;
            bit_cnt_q       <= bit_cnt_d;
            data_q          <= data_d;
            perr_q          <= perr_d;
            ferr_q          <= ferr_d;
            rx_data_q       <= rx_data_d;
            rx_perr_q       <= rx_perr_d;
            rx_ferr_q       <= rx_ferr_d;
            rx_valid_q      <= rx_valid_d;
            parity_error_q  <= parity_error_d;
            frame_error_q   <= frame_error_d;
            overrun_error_q <= overrun_error_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_perr       = rx_perr_q;
    assign rx_ferr       = rx_ferr_q;
    assign rx_valid      = rx_valid_q;
    assign busy          = (state_q != S_IDLE);
    assign parity_error  = parity_error_q;
    assign frame_error   = frame_error_q;
    assign overrun_error = overrun_error_q;

endmodule
